// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared types and helpers for the flexible-precision matmul PE:
//            precision tags, PE state encoding, digit-count and operand-mask
//            helpers.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Widest operand the mask helper can describe.
    localparam int MASK_MAX_W = 64;

    // Precision tag carried alongside the left operand; 2'b11 behaves as full.
    typedef enum logic [1:0] {
        PREC_Q = 2'b00,
        PREC_H = 2'b01,
        PREC_F = 2'b10
    } prec_e;

    // Processing-element sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WB   = 2'b10
    } pe_state_e;

    // Number of multiplier digits consumed for a given precision.
    function automatic int prec_digits(input logic [1:0] prec, input int data_w,
                                       input int digit_w);
        int total;
        total = data_w / digit_w;
        case (prec)
            PREC_Q:  return total / 4;
            PREC_H:  return total / 2;
            default: return total;
        endcase
    endfunction

    // Mask keeping only the top bits that a precision retains; low bits are
    // cleared, which floors a two's-complement operand.
    function automatic logic [MASK_MAX_W-1:0] prec_mask(input logic [1:0] prec,
                                                        input int data_w);
        int keep;
        logic [MASK_MAX_W-1:0] m;
        case (prec)
            PREC_Q:  keep = data_w / 4;
            PREC_H:  keep = data_w / 2;
            default: keep = data_w;
        endcase
        m = '0;
        for (int i = 0; i < MASK_MAX_W; i++) begin
            if ((i < data_w) && (i >= data_w - keep)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_signed.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter_signed
// Purpose  : Sign-magnitude iterative multiplier. Consumes one DIGIT_W digit
//            of |b| per cycle, most significant first, then realigns the
//            partial product for the digits that were skipped and restores
//            the sign. done_o marks the final iteration; product_o is valid
//            from the following cycle until the next start.
// Revision : 1.0 - initial release
// ============================================================================
module mul_iter_signed
    import matmul_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      n_digits_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int NDIG = DATA_W / DIGIT_W;
    localparam int P_W  = 2 * DATA_W;
    localparam int SH_W = $clog2(P_W);

    logic [DATA_W-1:0]  mag_a_q;
    logic [DATA_W-1:0]  b_sh_q;
    logic [P_W-1:0]     p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic [SH_W-1:0]    shamt_q;
    logic [P_W-1:0]     product_q;

    logic [DATA_W-1:0]          w_mag_a;
    logic [DATA_W-1:0]          w_mag_b;
    logic [DIGIT_W-1:0]         w_digit;
    logic [DATA_W+DIGIT_W-1:0]  w_pp;
    logic [P_W-1:0]             w_p_step;
    logic [P_W-1:0]             w_shifted;

    // Magnitudes fit DATA_W unsigned bits, including the most negative input.
    assign w_mag_a   = a_i[DATA_W-1] ? -a_i : a_i;
    assign w_mag_b   = b_i[DATA_W-1] ? -b_i : b_i;
    assign w_digit   = b_sh_q[DATA_W-1 -: DIGIT_W];
    assign w_pp      = {{DIGIT_W{1'b0}}, mag_a_q} * {{DATA_W{1'b0}}, w_digit};
    assign w_p_step  = (p_q << DIGIT_W) + {{(P_W-DATA_W-DIGIT_W){1'b0}}, w_pp};
    assign w_shifted = w_p_step << shamt_q;

    assign done_o    = (cnt_q == CNT_W'(1));
    assign product_o = product_q;

    // Load operands on start, then step one digit per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_a_q   <= '0;
            b_sh_q    <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            shamt_q   <= '0;
            product_q <= '0;
        end else if (start_i) begin
            mag_a_q <= w_mag_a;
            b_sh_q  <= w_mag_b;
            p_q     <= '0;
            cnt_q   <= n_digits_i;
            sign_q  <= a_i[DATA_W-1] ^ b_i[DATA_W-1];
            shamt_q <= SH_W'((NDIG - int'(n_digits_i)) * DIGIT_W);
        end else if (cnt_q != '0) begin
            p_q    <= w_p_step;
            b_sh_q <= b_sh_q << DIGIT_W;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                product_q <= sign_q ? -w_shifted : w_shifted;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_pe_flex.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pe_flex
// Purpose  : Systolic-array processing element with ready/valid on every
//            edge, runtime operand precision, and a tagged, optionally
//            saturating accumulation result delivered through a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_pe_flex
    import matmul_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DIGIT_W  = 4,
    parameter int ACC_W    = 40,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_clear,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [DATA_W-1:0]  a_in,
    input  logic [1:0]         prec_in,
    input  logic               last_in,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [DATA_W-1:0]  b_in,
    output logic               a_valid_out,
    input  logic               a_out_ready,
    output logic [DATA_W-1:0]  a_out,
    output logic [1:0]         prec_out,
    output logic               last_out,
    output logic               b_valid_out,
    input  logic               b_out_ready,
    output logic [DATA_W-1:0]  b_out,
    output logic               c_valid,
    input  logic               c_ready,
    output logic [ACC_W-1:0]   c_out,
    output logic               c_ovf
);

    localparam int NDIG  = DATA_W / DIGIT_W;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int P_W   = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    pe_state_e          state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic               last_q;

    logic               a_valid_out_q, b_valid_out_q;
    logic [DATA_W-1:0]  a_out_q, b_out_q;
    logic [1:0]         prec_out_q;
    logic               last_out_q;

    logic               c_valid_q;
    logic [ACC_W-1:0]   c_out_q;
    logic               c_ovf_q;

    logic [DATA_W-1:0]  w_mask, w_a_m, w_b_m;
    logic [CNT_W-1:0]   w_n;
    logic               w_mul_done;
    logic [P_W-1:0]     w_product;
    logic [ACC_W:0]     w_p_ext, w_sum;
    logic               w_new_ovf;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_wb_done, w_emit, w_engine_free, w_fire;

    // ---------------- handshake ----------------
    // A last-group write-back can only retire once the result register is free.
    assign w_wb_done     = (state_q == ST_WB) & (~last_q | ~c_valid_q | c_ready);
    assign w_emit        = (state_q == ST_WB) & last_q & (~c_valid_q | c_ready);
    assign w_engine_free = (state_q == ST_IDLE) | w_wb_done;
    assign w_fire        = a_valid & b_valid & w_engine_free
                         & (~a_valid_out_q | a_out_ready)
                         & (~b_valid_out_q | b_out_ready);
    assign a_ready       = w_fire;
    assign b_ready       = w_fire;

    // ---------------- precision and multiplier ----------------
    assign w_mask = DATA_W'(prec_mask(prec_in, DATA_W));
    assign w_a_m  = a_in & w_mask;
    assign w_b_m  = b_in & w_mask;
    assign w_n    = CNT_W'(prec_digits(prec_in, DATA_W, DIGIT_W));

    mul_iter_signed #(
        .DATA_W  (DATA_W),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (w_fire),
        .n_digits_i (w_n),
        .a_i        (w_a_m),
        .b_i        (w_b_m),
        .done_o     (w_mul_done),
        .product_o  (w_product)
    );

    // ---------------- accumulate with overflow detection ----------------
    assign w_p_ext   = {{(ACC_W+1-P_W){w_product[P_W-1]}}, w_product};
    assign w_sum     = {acc_q[ACC_W-1], acc_q} + w_p_ext;
    assign w_new_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    generate
        if (SATURATE) begin : g_sat
            assign w_acc_next = w_new_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                          : w_sum[ACC_W-1:0];
        end else begin : g_wrap
            assign w_acc_next = w_sum[ACC_W-1:0];
        end
    endgenerate

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: WB can chain straight into MUL when a new pair fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_fire)     state_d = ST_MUL;
            ST_MUL:  if (w_mul_done) state_d = ST_WB;
            ST_WB:   if (w_wb_done)  state_d = w_fire ? ST_MUL : ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Last tag travels with the pair through the multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else if (w_fire) begin
            last_q <= last_in;
        end
    end

    // Accumulator: emitted groups restart from zero; a clear drops a non-last product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (w_emit || acc_clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (w_wb_done) begin
            acc_q <= w_acc_next;
            ovf_q <= ovf_q | w_new_ovf;
        end
    end

    // Result register: holds while unconsumed, refills in the cycle it drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid_q <= 1'b0;
            c_out_q   <= '0;
            c_ovf_q   <= 1'b0;
        end else if (w_emit) begin
            c_valid_q <= 1'b1;
            c_out_q   <= w_acc_next;
            c_ovf_q   <= ovf_q | w_new_ovf;
        end else if (c_ready) begin
            c_valid_q <= 1'b0;
        end
    end

    // Forward slots: load raw operands on fire, release when each neighbour takes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_out_q <= 1'b0;
            b_valid_out_q <= 1'b0;
            a_out_q       <= '0;
            b_out_q       <= '0;
            prec_out_q    <= '0;
            last_out_q    <= 1'b0;
        end else if (w_fire) begin
            a_valid_out_q <= 1'b1;
            b_valid_out_q <= 1'b1;
            a_out_q       <= a_in;
            b_out_q       <= b_in;
            prec_out_q    <= prec_in;
            last_out_q    <= last_in;
        end else begin
            if (a_out_ready) a_valid_out_q <= 1'b0;
            if (b_out_ready) b_valid_out_q <= 1'b0;
        end
    end

    assign a_valid_out = a_valid_out_q;
    assign a_out       = a_out_q;
    assign prec_out    = prec_out_q;
    assign last_out    = last_out_q;
    assign b_valid_out = b_valid_out_q;
    assign b_out       = b_out_q;
    assign c_valid     = c_valid_q;
    assign c_out       = c_out_q;
    assign c_ovf       = c_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_pe_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_pe_flex
// Purpose  : Directed self-checking bench for matmul_pe_flex. One default
//            instance plus two ACC_W=32 instances (saturating / wrapping)
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_pe_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic        rst_n, acc_clear, a_valid, b_valid, last_in;
    logic        a_out_ready, b_out_ready, c_ready;
    logic [15:0] a_in, b_in;
    logic [1:0]  prec_in;

    logic        d_a_ready, d_b_ready, d_a_valid_out, d_last_out, d_b_valid_out, d_c_valid, d_c_ovf;
    logic [15:0] d_a_out, d_b_out;
    logic [1:0]  d_prec_out;
    logic [39:0] d_c_out;

    logic        s_a_ready, s_b_ready, s_a_valid_out, s_last_out, s_b_valid_out, s_c_valid, s_c_ovf;
    logic [15:0] s_a_out, s_b_out;
    logic [1:0]  s_prec_out;
    logic [31:0] s_c_out;

    logic        w_a_ready, w_b_ready, w_a_valid_out, w_last_out, w_b_valid_out, w_c_valid, w_c_ovf;
    logic [15:0] w_a_out, w_b_out;
    logic [1:0]  w_prec_out;
    logic [31:0] w_c_out;

    matmul_pe_flex #(.DATA_W(16), .DIGIT_W(4), .ACC_W(40), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .acc_clear(acc_clear),
        .a_valid(a_valid), .a_ready(d_a_ready), .a_in(a_in), .prec_in(prec_in), .last_in(last_in),
        .b_valid(b_valid), .b_ready(d_b_ready), .b_in(b_in),
        .a_valid_out(d_a_valid_out), .a_out_ready(a_out_ready), .a_out(d_a_out),
        .prec_out(d_prec_out), .last_out(d_last_out),
        .b_valid_out(d_b_valid_out), .b_out_ready(b_out_ready), .b_out(d_b_out),
        .c_valid(d_c_valid), .c_ready(c_ready), .c_out(d_c_out), .c_ovf(d_c_ovf)
    );

    matmul_pe_flex #(.DATA_W(16), .DIGIT_W(4), .ACC_W(32), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .acc_clear(acc_clear),
        .a_valid(a_valid), .a_ready(s_a_ready), .a_in(a_in), .prec_in(prec_in), .last_in(last_in),
        .b_valid(b_valid), .b_ready(s_b_ready), .b_in(b_in),
        .a_valid_out(s_a_valid_out), .a_out_ready(a_out_ready), .a_out(s_a_out),
        .prec_out(s_prec_out), .last_out(s_last_out),
        .b_valid_out(s_b_valid_out), .b_out_ready(b_out_ready), .b_out(s_b_out),
        .c_valid(s_c_valid), .c_ready(c_ready), .c_out(s_c_out), .c_ovf(s_c_ovf)
    );

    matmul_pe_flex #(.DATA_W(16), .DIGIT_W(4), .ACC_W(32), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .acc_clear(acc_clear),
        .a_valid(a_valid), .a_ready(w_a_ready), .a_in(a_in), .prec_in(prec_in), .last_in(last_in),
        .b_valid(b_valid), .b_ready(w_b_ready), .b_in(b_in),
        .a_valid_out(w_a_valid_out), .a_out_ready(a_out_ready), .a_out(w_a_out),
        .prec_out(w_prec_out), .last_out(w_last_out),
        .b_valid_out(w_b_valid_out), .b_out_ready(b_out_ready), .b_out(w_b_out),
        .c_valid(w_c_valid), .c_ready(c_ready), .c_out(w_c_out), .c_ovf(w_c_ovf)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and hold it until it fires (bounded); returns
    // one cycle after the fire edge with the valids dropped.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] p,
                         input logic l, output logic ok, output int fcyc);
        a_in = a; b_in = b; prec_in = p; last_in = l;
        a_valid = 1'b1; b_valid = 1'b1;
        ok = 1'b0; fcyc = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (d_a_ready === 1'b1) begin
                ok = 1'b1; fcyc = cyc;
                tick();
                break;
            end
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; last_in = 1'b0;
    endtask

    // Wait (bounded) for the default instance to present a result.
    task automatic wait_c(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (d_c_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({d_c_valid, d_a_valid_out, d_b_valid_out, d_c_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {d_c_valid, d_a_valid_out, d_b_valid_out, d_c_ovf});
        end
        n_checks++;
        if (d_c_out !== 40'd0) begin
            n_fail++; $display("FAIL reset_c_out got=%h exp=0", d_c_out);
        end
        n_checks++;
        if ({d_a_out, d_b_out, d_prec_out, d_last_out} !== 35'd0) begin
            n_fail++; $display("FAIL reset_fwd got=%h/%h exp=0", d_a_out, d_b_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_precision();
        logic ok; int fc;
        issue(16'd3, 16'hFFFB, 2'b10, 1'b1, ok, fc);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_fire got=%b exp=1", ok); end
        n_checks++;
        if ({d_a_valid_out, d_b_valid_out, d_a_out, d_b_out, d_last_out} !== {2'b11, 16'd3, 16'hFFFB, 1'b1}) begin
            n_fail++; $display("FAIL full_fwd got=%b%b a=%h b=%h exp=11 a=0003 b=fffb", d_a_valid_out, d_b_valid_out, d_a_out, d_b_out);
        end
        repeat (4) tick();
        n_checks++;
        if (d_c_valid !== 1'b0) begin n_fail++; $display("FAIL full_early got=%b exp=0", d_c_valid); end
        tick();
        n_checks++;
        if ({d_c_valid, d_c_out, d_c_ovf} !== {1'b1, 40'hFF_FFFF_FFF1, 1'b0}) begin
            n_fail++; $display("FAIL full_result got=v%b %h o%b exp=v1 fffffffff1 o0", d_c_valid, d_c_out, d_c_ovf);
        end
    endtask

    task automatic test_half_quarter();
        logic ok; int fc;
        issue(16'h1234, 16'h0100, 2'b01, 1'b1, ok, fc);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL half_fire got=%b exp=1", ok); end
        repeat (2) tick();
        n_checks++;
        if (d_c_valid !== 1'b0) begin n_fail++; $display("FAIL half_early got=%b exp=0", d_c_valid); end
        tick();
        n_checks++;
        if ({d_c_valid, d_c_out} !== {1'b1, 40'h0000120000}) begin
            n_fail++; $display("FAIL half_result got=v%b %h exp=v1 0000120000", d_c_valid, d_c_out);
        end
        issue(16'h7FFF, 16'h7FFF, 2'b00, 1'b1, ok, fc);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL quarter_fire got=%b exp=1", ok); end
        tick();
        n_checks++;
        if (d_c_valid !== 1'b0) begin n_fail++; $display("FAIL quarter_early got=%b exp=0", d_c_valid); end
        tick();
        n_checks++;
        if ({d_c_valid, d_c_out} !== {1'b1, 40'h0031000000}) begin
            n_fail++; $display("FAIL quarter_result got=v%b %h exp=v1 0031000000", d_c_valid, d_c_out);
        end
    endtask

    task automatic test_accumulate();
        logic ok0, ok1, ok2, seen; int f0, f1, f2;
        issue(16'd2, 16'd3, 2'b10, 1'b0, ok0, f0);
        issue(16'd4, 16'd5, 2'b10, 1'b0, ok1, f1);
        issue(16'hFFFF, 16'd7, 2'b10, 1'b1, ok2, f2);
        n_checks++;
        if ({ok0, ok1, ok2} !== 3'b111) begin n_fail++; $display("FAIL acc_fires got=%b exp=111", {ok0, ok1, ok2}); end
        n_checks++;
        if (f1 - f0 !== 5) begin n_fail++; $display("FAIL acc_gap1 got=%0d exp=5", f1 - f0); end
        n_checks++;
        if (f2 - f1 !== 5) begin n_fail++; $display("FAIL acc_gap2 got=%0d exp=5", f2 - f1); end
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out, d_c_ovf} !== {1'b1, 40'd19, 1'b0}) begin
            n_fail++; $display("FAIL acc_result got=seen%b %h o%b exp=seen1 19 o0", seen, d_c_out, d_c_ovf);
        end
        issue(16'd1, 16'd1, 2'b10, 1'b1, ok0, f0);
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd1}) begin
            n_fail++; $display("FAIL acc_restart got=seen%b %h exp=seen1 1", seen, d_c_out);
        end
    endtask

    task automatic test_saturation();
        logic ok, seen; int fc;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        issue(16'h7FFF, 16'h7FFF, 2'b10, 1'b0, ok, fc);
        issue(16'h7FFF, 16'h7FFF, 2'b10, 1'b0, ok, fc);
        issue(16'h7FFF, 16'h7FFF, 2'b10, 1'b1, ok, fc);
        wait_c(seen);
        n_checks++;
        if ({seen, s_c_valid, w_c_valid} !== 3'b111) begin
            n_fail++; $display("FAIL sat_valid got=%b exp=111", {seen, s_c_valid, w_c_valid});
        end
        n_checks++;
        if ({s_c_out, s_c_ovf} !== {32'h7FFFFFFF, 1'b1}) begin
            n_fail++; $display("FAIL sat_clamp got=%h o%b exp=7fffffff o1", s_c_out, s_c_ovf);
        end
        n_checks++;
        if ({w_c_out, w_c_ovf} !== {32'hBFFD0003, 1'b1}) begin
            n_fail++; $display("FAIL sat_wrap got=%h o%b exp=bffd0003 o1", w_c_out, w_c_ovf);
        end
        n_checks++;
        if ({d_c_out, d_c_ovf} !== {40'h00BFFD0003, 1'b0}) begin
            n_fail++; $display("FAIL sat_wide got=%h o%b exp=00bffd0003 o0", d_c_out, d_c_ovf);
        end
        tick();
    endtask

    task automatic test_result_backpressure();
        logic ok, seen; int fc;
        c_ready = 1'b0;
        issue(16'd2, 16'd3, 2'b10, 1'b1, ok, fc);
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd6}) begin n_fail++; $display("FAIL bp_first got=seen%b %h exp=seen1 6", seen, d_c_out); end
        issue(16'd1, 16'd1, 2'b10, 1'b1, ok, fc);
        repeat (8) tick();
        n_checks++;
        if ({ok, d_c_valid, d_c_out} !== {2'b11, 40'd6}) begin
            n_fail++; $display("FAIL bp_hold got=ok%b v%b %h exp=ok1 v1 6", ok, d_c_valid, d_c_out);
        end
        a_in = 16'd5; b_in = 16'd5; prec_in = 2'b10; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        n_checks++;
        if ({d_a_ready, d_b_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_stall got=%b exp=00", {d_a_ready, d_b_ready}); end
        a_valid = 1'b0; b_valid = 1'b0;
        c_ready = 1'b1;
        tick();
        n_checks++;
        if ({d_c_valid, d_c_out} !== {1'b1, 40'd1}) begin n_fail++; $display("FAIL bp_second got=v%b %h exp=v1 1", d_c_valid, d_c_out); end
        tick();
        n_checks++;
        if (d_c_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", d_c_valid); end
    endtask

    task automatic test_fwd_backpressure();
        logic ok, seen; int fc;
        a_out_ready = 1'b0;
        issue(16'd1, 16'd2, 2'b10, 1'b1, ok, fc);
        wait_c(seen);
        n_checks++;
        if ({ok, seen, d_c_out} !== {2'b11, 40'd2}) begin n_fail++; $display("FAIL fwd_first got=%b%b %h exp=11 2", ok, seen, d_c_out); end
        a_in = 16'd3; b_in = 16'd4; prec_in = 2'b10; last_in = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        n_checks++;
        if ({d_a_valid_out, d_a_ready} !== 2'b10) begin n_fail++; $display("FAIL fwd_block got=%b exp=10", {d_a_valid_out, d_a_ready}); end
        tick(); tick();
        n_checks++;
        if ({d_a_ready, d_a_out} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL fwd_hold got=r%b %h exp=r0 0001", d_a_ready, d_a_out); end
        a_out_ready = 1'b1;
        #1;
        n_checks++;
        if (d_a_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_release got=%b exp=1", d_a_ready); end
        tick();
        a_valid = 1'b0; b_valid = 1'b0; last_in = 1'b0;
        n_checks++;
        if ({d_a_valid_out, d_a_out} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL fwd_reload got=v%b %h exp=v1 0003", d_a_valid_out, d_a_out); end
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd12}) begin n_fail++; $display("FAIL fwd_second got=seen%b %h exp=seen1 12", seen, d_c_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic ok, seen, any_c; int fc;
        issue(16'd5, 16'd5, 2'b10, 1'b1, ok, fc);
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({d_c_valid, d_a_valid_out, d_b_valid_out, d_c_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_flags got=%b exp=0000", {d_c_valid, d_a_valid_out, d_b_valid_out, d_c_ovf});
        end
        n_checks++;
        if ({d_c_out, d_a_out, d_b_out} !== 72'd0) begin
            n_fail++; $display("FAIL rstmid_data got=%h %h %h exp=0", d_c_out, d_a_out, d_b_out);
        end
        rst_n = 1'b1;
        any_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (d_c_valid === 1'b1) any_c = 1'b1;
        end
        n_checks++;
        if (any_c !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result got=%b exp=0", any_c); end
        issue(16'd1, 16'd1, 2'b10, 1'b1, ok, fc);
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd1}) begin n_fail++; $display("FAIL rstmid_after got=seen%b %h exp=seen1 1", seen, d_c_out); end
        tick();
    endtask

    task automatic test_acc_clear();
        logic ok, seen; int fc;
        issue(16'd2, 16'd3, 2'b10, 1'b0, ok, fc);
        repeat (4) tick();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        issue(16'd1, 16'd1, 2'b10, 1'b1, ok, fc);
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd1}) begin n_fail++; $display("FAIL clear_drop got=seen%b %h exp=seen1 1", seen, d_c_out); end
        issue(16'd2, 16'd2, 2'b10, 1'b1, ok, fc);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        wait_c(seen);
        n_checks++;
        if ({seen, d_c_out} !== {1'b1, 40'd4}) begin n_fail++; $display("FAIL clear_mul got=seen%b %h exp=seen1 4", seen, d_c_out); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; acc_clear = 1'b0; a_valid = 1'b0; b_valid = 1'b0; last_in = 1'b0;
        a_in = '0; b_in = '0; prec_in = 2'b10;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_ready = 1'b1;
        #1;
        test_reset();
        test_full_precision();
        test_half_quarter();
        test_accumulate();
        test_saturation();
        test_result_backpressure();
        test_fwd_backpressure();
        test_reset_mid();
        test_acc_clear();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
